// File: rtl/uart_transmitter.sv
// UART transmit half: one byte per valid/ready handshake, sent as an 8N1 frame.
// Datapath registers (shift, clock count, bit count, line) are advanced by a two-process FSM.
module uart_transmitter #(
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int CLOCKS_PER_BIT      = 434,
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_tx_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_tx_ready,
  output logic                  o_tx_busy,
  output logic                  o_tx_done,
  output logic                  o_tx_serial
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_LAST =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] BIT_LAST =
    BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  state_t                         state, state_n;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt, clk_cnt_n;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0]          shift, shift_n;
  logic                           serial_q, serial_n;
  logic                           done_q, done_n;
  logic                           bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);

  // Next-state and datapath decode; the line level is decided here and then registered.
  always_comb begin
    state_n   = state;
    clk_cnt_n = (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    serial_n  = serial_q;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        serial_n = 1'b1;
        if (i_tx_valid) begin
          shift_n  = i_tx_data;
          state_n  = START;
          serial_n = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          serial_n  = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            serial_n  = shift_n[0];
          end
        end
      end
      STOP: begin
        serial_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame and idles the line high.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      serial_q <= serial_n;
      done_q   <= done_n;
    end
  end

  assign o_tx_ready  = (state == IDLE);
  assign o_tx_busy   = ~o_tx_ready;
  assign o_tx_done   = done_q;
  assign o_tx_serial = serial_q;

endmodule
